// File: rtl/rms_finalizer.sv
// rms_finalizer: turns a (sum of squares, sample count) pair into mean = floor(sum/N)
// and rms = floor(sqrt(mean)) using a bit-serial restoring divider and a bit-pair square root.
module rms_finalizer #(
   parameter int SUM_WIDTH = 64,
   parameter int N_WIDTH   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [SUM_WIDTH-1:0]   in_data,
   input  logic [N_WIDTH-1:0]     in_data_N,
   input  logic                   in_data_valid,
   output logic [SUM_WIDTH-1:0]   out_data_mean,
   output logic [SUM_WIDTH/2-1:0] out_data_rms,
   output logic                   out_data_valid,
   output logic                   out_error,
   output logic                   out_overrun,
   output logic                   busy,
   output logic [1:0]             dbg_state_o
);

   localparam int HALF = SUM_WIDTH / 2;
   localparam int CW   = $clog2(SUM_WIDTH);

   // Handshake: in_data_valid is a one-cycle strobe with no back-pressure. It is accepted only
   // when busy is low; a strobe seen while busy is dropped and reported by out_overrun on the
   // next cycle. out_data_valid is a one-cycle pulse and the downstream cannot stall it.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      SQRT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state_q;
   logic [SUM_WIDTH-1:0] work_q;      // dividend/quotient during DIV, radicand during SQRT
   logic [N_WIDTH-1:0]   divisor_q;
   logic [N_WIDTH:0]     rem_q;
   logic [SUM_WIDTH-1:0] mean_q;
   logic [HALF+1:0]      sq_rem_q;
   logic [HALF-1:0]      root_q;
   logic                 err_q;
   logic [CW-1:0]        cnt_q;
   logic [SUM_WIDTH-1:0] out_mean_q;
   logic [HALF-1:0]      out_rms_q;
   logic                 out_valid_q;
   logic                 out_err_q;
   logic                 overrun_q;

   logic [N_WIDTH:0]     rem_shift;
   logic                 div_ge;
   logic [N_WIDTH:0]     rem_d;
   logic [SUM_WIDTH-1:0] quo_d;
   logic [HALF+1:0]      sq_shift;
   logic [HALF+1:0]      sq_trial;
   logic                 sq_ge;
   logic [HALF+1:0]      sq_rem_d;
   logic [HALF-1:0]      root_d;
   logic [SUM_WIDTH-1:0] rad_d;

   always_comb begin
      // One restoring-division step: bring down the next dividend bit, subtract if it fits.
      rem_shift = (rem_q << 1) | {{N_WIDTH{1'b0}}, work_q[SUM_WIDTH-1]};
      div_ge    = (rem_shift >= {1'b0, divisor_q});
      rem_d     = div_ge ? (rem_shift - {1'b0, divisor_q}) : rem_shift;
      quo_d     = {work_q[SUM_WIDTH-2:0], div_ge};

      // One square-root step: bring down two radicand bits, try subtracting 4*root+1.
      sq_shift  = (sq_rem_q << 2) | {{HALF{1'b0}}, work_q[SUM_WIDTH-1 -: 2]};
      sq_trial  = {root_q, 2'b01};
      sq_ge     = (sq_shift >= sq_trial);
      sq_rem_d  = sq_ge ? (sq_shift - sq_trial) : sq_shift;
      root_d    = {root_q[HALF-2:0], sq_ge};
      rad_d     = {work_q[SUM_WIDTH-3:0], 2'b00};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         work_q      <= '0;
         divisor_q   <= '0;
         rem_q       <= '0;
         mean_q      <= '0;
         sq_rem_q    <= '0;
         root_q      <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         out_mean_q  <= '0;
         out_rms_q   <= '0;
         out_valid_q <= 1'b0;
         out_err_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         overrun_q   <= in_data_valid && (state_q != IDLE);
         case (state_q)
            IDLE: begin
               if (in_data_valid) begin
                  divisor_q <= in_data_N;
                  rem_q     <= '0;
                  cnt_q     <= CW'(SUM_WIDTH - 1);
                  if (in_data_N == '0) begin
                     mean_q  <= '0;
                     root_q  <= '0;
                     err_q   <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     work_q  <= in_data;
                     err_q   <= 1'b0;
                     state_q <= DIV;
                  end
               end
            end
            DIV: begin
               work_q <= quo_d;
               rem_q  <= rem_d;
               if (cnt_q == '0) begin
                  // Quotient complete: it is both the mean and the radicand for SQRT.
                  mean_q   <= quo_d;
                  sq_rem_q <= '0;
                  root_q   <= '0;
                  cnt_q    <= CW'(HALF - 1);
                  state_q  <= SQRT;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            SQRT: begin
               sq_rem_q <= sq_rem_d;
               root_q   <= root_d;
               work_q   <= rad_d;
               if (cnt_q == '0) begin
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               out_mean_q  <= mean_q;
               out_rms_q   <= root_q;
               out_err_q   <= err_q;
               out_valid_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_data_mean  = out_mean_q;
   assign out_data_rms   = out_rms_q;
   assign out_data_valid = out_valid_q;
   assign out_error      = out_err_q;
   assign out_overrun    = overrun_q;
   assign busy           = (state_q != IDLE);
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_rms_finalizer.sv
// Directed self-checking bench for rms_finalizer: latency, values, N=0, overrun,
// back-to-back acceptance and mid-operation reset.
module tb_rms_finalizer;

   logic        clk;
   logic        rst;
   logic [63:0] in_data;
   logic [31:0] in_data_N;
   logic        in_data_valid;
   logic [63:0] out_data_mean;
   logic [31:0] out_data_rms;
   logic        out_data_valid;
   logic        out_error;
   logic        out_overrun;
   logic        busy;
   logic [1:0]  dbg_state;

   int n_checks;
   int n_fail;

   rms_finalizer #(.SUM_WIDTH(64), .N_WIDTH(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_data        (in_data),
      .in_data_N      (in_data_N),
      .in_data_valid  (in_data_valid),
      .out_data_mean  (out_data_mean),
      .out_data_rms   (out_data_rms),
      .out_data_valid (out_data_valid),
      .out_error      (out_error),
      .out_overrun    (out_overrun),
      .busy           (busy),
      .dbg_state_o    (dbg_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int NV = 12;
   localparam logic [63:0] V_SUM [NV] = '{
      64'd99, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd17,
      64'hFFFF_FFFF_FFFF_FFFF, 64'd1000000, 64'd0, 64'hFFFF_FFFE_0000_0001,
      64'hFFFF_FFFE_0000_0000, 64'h8000_0000_0000_0000, 64'd7, 64'd80};
   localparam logic [31:0] V_N [NV] = '{
      32'd10, 32'd1, 32'd7, 32'd1,
      32'hFFFF_FFFF, 32'd3, 32'd5, 32'd1,
      32'd1, 32'd2, 32'd7, 32'd9};
   localparam logic [63:0] V_MEAN [NV] = '{
      64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd17,
      64'h1_0000_0001, 64'd333333, 64'd0, 64'hFFFF_FFFE_0000_0001,
      64'hFFFF_FFFE_0000_0000, 64'h4000_0000_0000_0000, 64'd1, 64'd8};
   localparam logic [31:0] V_RMS [NV] = '{
      32'd3, 32'hFFFF_FFFF, 32'd0, 32'd4,
      32'h0001_0000, 32'd577, 32'd0, 32'hFFFF_FFFF,
      32'hFFFF_FFFE, 32'h8000_0000, 32'd1, 32'd2};

   // Driver: strobes one request (edge E0), then watches `window` cycles. Index k is the
   // falling edge after rising edge Ek. An optional second strobe is sampled at E(extra_k).
   task automatic run_req(input logic [63:0] sum, input logic [31:0] n,
                          input int extra_k, input logic [63:0] x_sum, input logic [31:0] x_n,
                          input int window,
                          output int lat1, output logic [63:0] mean1, output logic [31:0] rms1,
                          output logic err1, output logic busy_v,
                          output int lat2, output logic [63:0] mean2, output logic [31:0] rms2,
                          output int npulse, output int ovr_k, output int novr,
                          output logic busy_k0);
      lat1 = -1; lat2 = -1; mean1 = '0; rms1 = '0; err1 = 1'bx; busy_v = 1'bx;
      mean2 = '0; rms2 = '0; npulse = 0; ovr_k = -1; novr = 0;
      @(negedge clk);
      in_data = sum; in_data_N = n; in_data_valid = 1'b1;
      @(negedge clk);
      in_data_valid = 1'b0;
      busy_k0 = busy;
      for (int k = 1; k <= window; k++) begin
         @(negedge clk);
         if (out_data_valid === 1'b1) begin
            npulse++;
            if (npulse == 1) begin
               lat1 = k; mean1 = out_data_mean; rms1 = out_data_rms;
               err1 = out_error; busy_v = busy;
            end else if (npulse == 2) begin
               lat2 = k; mean2 = out_data_mean; rms2 = out_data_rms;
            end
         end
         if (out_overrun === 1'b1) begin
            novr++;
            if (ovr_k < 0) ovr_k = k;
         end
         if (k == extra_k - 1) begin
            in_data = x_sum; in_data_N = x_n; in_data_valid = 1'b1;
         end else if (k == extra_k) begin
            in_data_valid = 1'b0;
         end
      end
   endtask

   int lat1, lat2, npulse, ovr_k, novr;
   logic [63:0] mean1, mean2;
   logic [31:0] rms1, rms2;
   logic err1, busy_v, busy_k0;

   task automatic test_reset();
      rst = 1'b1; in_data = '0; in_data_N = '0; in_data_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (out_data_mean !== 64'd0) begin n_fail++; $display("FAIL reset_mean got=%0h exp=0", out_data_mean); end
      n_checks++; if (out_data_rms !== 32'd0) begin n_fail++; $display("FAIL reset_rms got=%0h exp=0", out_data_rms); end
      n_checks++; if (out_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_data_valid); end
      n_checks++; if (out_error !== 1'b0 || out_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_err_ovr got=%b%b exp=00", out_error, out_overrun); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      run_req(64'd1000, 32'd10, 0, 64'd0, 32'd0, 110, lat1, mean1, rms1, err1, busy_v,
              lat2, mean2, rms2, npulse, ovr_k, novr, busy_k0);
      n_checks++; if (lat1 !== 97) begin n_fail++; $display("FAIL basic_latency got=%0d exp=97", lat1); end
      n_checks++; if (npulse !== 1) begin n_fail++; $display("FAIL basic_pulses got=%0d exp=1", npulse); end
      n_checks++; if (mean1 !== 64'd100) begin n_fail++; $display("FAIL basic_mean got=%0d exp=100", mean1); end
      n_checks++; if (rms1 !== 32'd10) begin n_fail++; $display("FAIL basic_rms got=%0d exp=10", rms1); end
      n_checks++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL basic_err got=%b exp=0", err1); end
      n_checks++; if (busy_k0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got=%b exp=1", busy_k0); end
      n_checks++; if (busy_v !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_valid got=%b exp=0", busy_v); end
      n_checks++; if (novr !== 0) begin n_fail++; $display("FAIL basic_overrun got=%0d exp=0", novr); end
      n_checks++; if (out_data_mean !== 64'd100 || out_data_rms !== 32'd10) begin n_fail++; $display("FAIL basic_hold got=%0d/%0d exp=100/10", out_data_mean, out_data_rms); end
   endtask

   task automatic test_values();
      for (int i = 0; i < NV; i++) begin
         run_req(V_SUM[i], V_N[i], 0, 64'd0, 32'd0, 100, lat1, mean1, rms1, err1, busy_v,
                 lat2, mean2, rms2, npulse, ovr_k, novr, busy_k0);
         n_checks++; if (lat1 !== 97) begin n_fail++; $display("FAIL values_latency[%0d] got=%0d exp=97", i, lat1); end
         n_checks++; if (mean1 !== V_MEAN[i]) begin n_fail++; $display("FAIL values_mean[%0d] got=%0h exp=%0h", i, mean1, V_MEAN[i]); end
         n_checks++; if (rms1 !== V_RMS[i]) begin n_fail++; $display("FAIL values_rms[%0d] got=%0h exp=%0h", i, rms1, V_RMS[i]); end
         n_checks++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL values_err[%0d] got=%b exp=0", i, err1); end
      end
   endtask

   task automatic test_n_zero();
      run_req(64'd5, 32'd0, 0, 64'd0, 32'd0, 20, lat1, mean1, rms1, err1, busy_v,
              lat2, mean2, rms2, npulse, ovr_k, novr, busy_k0);
      n_checks++; if (lat1 !== 1) begin n_fail++; $display("FAIL nzero_latency got=%0d exp=1", lat1); end
      n_checks++; if (npulse !== 1) begin n_fail++; $display("FAIL nzero_pulses got=%0d exp=1", npulse); end
      n_checks++; if (err1 !== 1'b1) begin n_fail++; $display("FAIL nzero_err got=%b exp=1", err1); end
      n_checks++; if (mean1 !== 64'd0 || rms1 !== 32'd0) begin n_fail++; $display("FAIL nzero_result got=%0h/%0h exp=0/0", mean1, rms1); end
      n_checks++; if (busy_k0 !== 1'b1 || busy_v !== 1'b0) begin n_fail++; $display("FAIL nzero_busy got=%b%b exp=10", busy_k0, busy_v); end
      run_req(64'd16, 32'd1, 0, 64'd0, 32'd0, 100, lat1, mean1, rms1, err1, busy_v,
              lat2, mean2, rms2, npulse, ovr_k, novr, busy_k0);
      n_checks++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL nzero_err_cleared got=%b exp=0", err1); end
      n_checks++; if (mean1 !== 64'd16 || rms1 !== 32'd4) begin n_fail++; $display("FAIL nzero_next got=%0d/%0d exp=16/4", mean1, rms1); end
   endtask

   task automatic test_overrun();
      run_req(64'd400, 32'd4, 30, 64'd9, 32'd1, 110, lat1, mean1, rms1, err1, busy_v,
              lat2, mean2, rms2, npulse, ovr_k, novr, busy_k0);
      n_checks++; if (ovr_k !== 30) begin n_fail++; $display("FAIL ovr_cycle got=%0d exp=30", ovr_k); end
      n_checks++; if (novr !== 1) begin n_fail++; $display("FAIL ovr_width got=%0d exp=1", novr); end
      n_checks++; if (npulse !== 1 || lat1 !== 97) begin n_fail++; $display("FAIL ovr_valid got=%0d@%0d exp=1@97", npulse, lat1); end
      n_checks++; if (mean1 !== 64'd100 || rms1 !== 32'd10) begin n_fail++; $display("FAIL ovr_result got=%0d/%0d exp=100/10", mean1, rms1); end
   endtask

   task automatic test_back_to_back();
      run_req(64'd1000, 32'd10, 98, 64'd100, 32'd4, 200, lat1, mean1, rms1, err1, busy_v,
              lat2, mean2, rms2, npulse, ovr_k, novr, busy_k0);
      n_checks++; if (npulse !== 2) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp=2", npulse); end
      n_checks++; if (lat1 !== 97 || lat2 !== 195) begin n_fail++; $display("FAIL b2b_latency got=%0d,%0d exp=97,195", lat1, lat2); end
      n_checks++; if (mean2 !== 64'd25 || rms2 !== 32'd5) begin n_fail++; $display("FAIL b2b_result got=%0d/%0d exp=25/5", mean2, rms2); end
      n_checks++; if (novr !== 0) begin n_fail++; $display("FAIL b2b_overrun got=%0d exp=0", novr); end
   endtask

   task automatic test_reset_mid();
      int pulses;
      pulses = 0;
      @(negedge clk);
      in_data = 64'd1000; in_data_N = 32'd10; in_data_valid = 1'b1;
      @(negedge clk);
      in_data_valid = 1'b0;
      repeat (50) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++; if (out_data_mean !== 64'd0 || out_data_rms !== 32'd0) begin n_fail++; $display("FAIL rstmid_outputs got=%0d/%0d exp=0/0", out_data_mean, out_data_rms); end
      n_checks++; if (busy !== 1'b0 || out_data_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_valid got=%b%b exp=00", busy, out_data_valid); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (out_data_valid === 1'b1) pulses++;
      end
      n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rstmid_no_valid got=%0d exp=0", pulses); end
      run_req(64'd64, 32'd1, 0, 64'd0, 32'd0, 100, lat1, mean1, rms1, err1, busy_v,
              lat2, mean2, rms2, npulse, ovr_k, novr, busy_k0);
      n_checks++; if (mean1 !== 64'd64 || rms1 !== 32'd8 || lat1 !== 97) begin n_fail++; $display("FAIL rstmid_after got=%0d/%0d@%0d exp=64/8@97", mean1, rms1, lat1); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_basic();
      test_values();
      test_n_zero();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rms_finalizer.md
# rms_finalizer

Converts the raw accumulations produced by the per-window integrators into final RMS figures. It takes a sum of squared samples and a sample count N, computes mean = floor(sum / N) with a sequential restoring divider, then computes rms = floor(sqrt(mean)) with a sequential digit-by-digit square root. It sits directly downstream of the variable-window RMS integrator and consumes its out_data / out_data_N / out_data_valid triple. Its results go to the AXI-Lite register bank.

## Interface
- SUM_WIDTH, 64, width of the unsigned sum-of-squares input and of the mean output; must be even.
- N_WIDTH, 32, width of the unsigned sample-count input.
- clk  in  1  single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  SUM_WIDTH  unsigned sum of squared samples.
- in_data_N  in  N_WIDTH  unsigned sample count of the window.
- in_data_valid  in  1  single-cycle strobe; captures in_data and in_data_N.
- out_data_mean  out  SUM_WIDTH  floor(in_data / in_data_N).
- out_data_rms  out  SUM_WIDTH/2  floor(sqrt(out_data_mean)).
- out_data_valid  out  1  single-cycle pulse when new results are presented.
- out_error  out  1  qualified by out_data_valid; 1 when in_data_N was 0.
- out_overrun  out  1  single-cycle pulse when a strobe is dropped because the block is busy.
- busy  out  1  high while state is not IDLE.

## Operation
- Reset value of every output is 0.
- Reset clears all internal registers and returns the FSM to IDLE.
- States are IDLE, DIV, SQRT and DONE.
- **IDLE**
  - On in_data_valid=1, capture the inputs.
  - If N≠0, go to DIV.
  - If N=0, go to DONE with mean=0, rms=0 and error=1.
- **DIV**
  - Restoring long division, one quotient bit per clock, MSB first.
  - Partial remainder is N_WIDTH+1 bits wide; a bit count runs SUM_WIDTH−1 down to 0.
  - After SUM_WIDTH iterations the quotient is latched as the mean and the FSM goes to SQRT.
- **SQRT**
  - Integer square root, two radicand bits per clock.
  - Remainder is SUM_WIDTH/2+2 bits wide; the root grows one bit per clock.
  - After SUM_WIDTH/2 iterations the FSM goes to DONE.
- **DONE**
  - Register out_data_mean, out_data_rms and out_error.
  - Pulse out_data_valid for one cycle.
  - Return to IDLE.
- Result outputs hold their last values until the next DONE. out_error is rewritten at every DONE.
- An in_data_valid arriving in any state other than IDLE is ignored. It does not disturb the computation in progress and pulses out_overrun one cycle later.
- All arithmetic is unsigned. Neither quotient nor root can overflow: with N≥1, quotient ≤ 2^SUM_WIDTH−1 and root ≤ 2^(SUM_WIDTH/2)−1.
- Reset asserted mid-operation aborts the computation. No out_data_valid is produced for the aborted request.

## Timing
Let E0 be the rising edge that samples in_data_valid=1 in IDLE.
- **Normal case (N≠0)**
  - DIV iterations occur on edges E1..E(SUM_WIDTH).
  - SQRT iterations occur on edges E(SUM_WIDTH+1)..E(3·SUM_WIDTH/2).
  - DONE outputs are registered at edge E(3·SUM_WIDTH/2+1), which is E97 at the defaults.
  - out_data_valid is high for exactly the cycle between E97 and E98.
- **N=0 case**
  - Outputs are registered and out_data_valid goes high at E1.
  - out_data_valid is high for the cycle between E1 and E2.
- **busy**
  - Rises after E0.
  - Falls after the edge that asserts out_data_valid; it is low in that same cycle.
- **Back-to-back requests**
  - A strobe sampled during the out_data_valid cycle is accepted as a new E0.
  - Sustained throughput is therefore one result per 98 cycles at the defaults.
- **Overrun**
  - A strobe sampled while busy produces out_overrun high during the following cycle.

## Test plan
- in_data=1000, in_data_N=10 at E0: out_data_valid at E97 only; mean=100, rms=10, out_error=0; busy low from E97.
- in_data=99, N=10 produces mean=9, rms=3. Then in_data=2^64−1, N=1 produces mean=0xFFFF_FFFF_FFFF_FFFF, rms=0xFFFF_FFFF.
- in_data=5, N=0: out_data_valid at E1 with out_error=1, mean=0, rms=0. A following request with in_data=16, N=1 gives mean=16, rms=4 and out_error=0.
- First request in_data=400, N=4; second strobe at E30 with in_data=9, N=1:
  - out_overrun pulses after E30.
  - Only one out_data_valid occurs, at E97, carrying mean=100, rms=10.
- rst asserted at E50 of a request for 1000/10:
  - All outputs are 0 immediately (asynchronously) and busy=0.
  - No out_data_valid follows.
  - After release, a request of 64/1 yields mean=64, rms=8.
- Random regression of 10k (in_data, N≥1) pairs, including sums below N:
  - mean equals the floor quotient.
  - rms satisfies rms² ≤ mean < (rms+1)².
  - Each result arrives exactly 97 cycles after its strobe.
